poly_divmod_q: RTL

POLY_DIVMOD_Q -- requirements
Module: poly_divmod_q

---
 rtl/poly_divmod_q_pkg.sv | 30 +++
 rtl/modinv_fermat.sv | 61 ++++++
 rtl/poly_divmod_q.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/poly_divmod_q_pkg.sv
// Shared FSM state type, default parameters and mod-Q arithmetic helpers
// for the polynomial divider and its modular-inverse unit.
package poly_divmod_q_pkg;
  localparam int DEF_COEF_W = 13;
  localparam int DEF_Q      = 4621;
  localparam int DEF_N_MAX  = 677;
  localparam int CALC_W     = 32;

  typedef enum logic [2:0] {IDLE, SCAN, INV, QUOT, UPD, FIN} state_t;

  function automatic logic [CALC_W-1:0] mod_reduce(input logic [2*CALC_W-1:0] x,
                                                   input logic [CALC_W-1:0]   q);
    logic [2*CALC_W-1:0] r;
    r = x % {{CALC_W{1'b0}}, q};
    return r[CALC_W-1:0];
  endfunction

  function automatic logic [CALC_W-1:0] mod_mul(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input logic [CALC_W-1:0] q);
    return mod_reduce({{CALC_W{1'b0}}, a} * {{CALC_W{1'b0}}, b}, q);
  endfunction

  // Both operands are already below q, so a single conditional add of q suffices.
  function automatic logic [CALC_W-1:0] mod_sub(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input logic [CALC_W-1:0] q);
    return (a >= b) ? a - b : a + q - b;
  endfunction
endpackage

// File: rtl/modinv_fermat.sv
// Modular inverse by Fermat: inv = a^(Q-2) mod Q, MSB-first square-and-multiply,
// one exponent bit per cycle; done pulses COEF_W+1 cycles after start.
module modinv_fermat
  import poly_divmod_q_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int Q      = DEF_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COEF_W-1:0] a,
  output logic              done,
  output logic [COEF_W-1:0] inv
);
  localparam int BW = $clog2(COEF_W);
  localparam logic [COEF_W-1:0] EXP = COEF_W'(Q - 2);

  logic              running;
  logic [BW-1:0]     bit_idx;
  logic [COEF_W-1:0] a_reg;
  logic [COEF_W-1:0] sq;
  logic [COEF_W-1:0] step;

  function automatic logic [COEF_W-1:0] mulq(input logic [COEF_W-1:0] x,
                                             input logic [COEF_W-1:0] y);
    logic [CALC_W-1:0] r;
    r = mod_mul(CALC_W'(x), CALC_W'(y), CALC_W'(Q));
    return r[COEF_W-1:0];
  endfunction

  // NOTE: combinational blocks use blocking '=' and give every output a value on every path, so no latch is inferred.
  always_comb begin
    sq   = mulq(inv, inv);
    step = EXP[bit_idx] ? mulq(sq, a_reg) : sq;
  end

  // NOTE: only the handshake flags are reset; the datapath is reloaded by every start.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running <= 1'b1;
        bit_idx <= BW'(COEF_W - 1);
        a_reg   <= a;
        inv     <= COEF_W'(1);
      end else if (running) begin
        inv <= step;
        if (bit_idx == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          bit_idx <= bit_idx - BW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/poly_divmod_q.sv
// Polynomial long division over Z_Q: N = Qt*D + R with deg R < deg D,
// one coefficient update per cycle over register-based coefficient RAMs.
module poly_divmod_q
  import poly_divmod_q_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int Q      = DEF_Q,
  parameter int N_MAX  = DEF_N_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(N_MAX)-1:0] wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  input  logic                     start,
  input  logic                     rd_sel,
  input  logic [$clog2(N_MAX)-1:0] rd_addr,
  output logic [COEF_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(N_MAX)-1:0] deg_q
);
  localparam int AW = $clog2(N_MAX);
  localparam logic [AW-1:0] LAST = AW'(N_MAX - 1);

  logic [COEF_W-1:0] n_mem [N_MAX];
  logic [COEF_W-1:0] d_mem [N_MAX];
  logic [COEF_W-1:0] q_mem [N_MAX];

  state_t            state, state_nx;
  logic [AW-1:0]     idx, k, j, deg_n, deg_d;
  logic              found_n, found_d;
  logic [COEF_W-1:0] lc_d, t;

  logic [COEF_W-1:0] n_scan, d_scan, lc_d_nx, t_nx, n_upd, inv;
  logic              found_n_nx, found_d_nx, inv_start, inv_done, host_wr, normal;
  logic [AW-1:0]     deg_n_nx, deg_d_nx, upd_addr;

  function automatic logic [COEF_W-1:0] mulq(input logic [COEF_W-1:0] x,
                                             input logic [COEF_W-1:0] y);
    logic [CALC_W-1:0] r;
    r = mod_mul(CALC_W'(x), CALC_W'(y), CALC_W'(Q));
    return r[COEF_W-1:0];
  endfunction

  function automatic logic [COEF_W-1:0] subq(input logic [COEF_W-1:0] x,
                                             input logic [COEF_W-1:0] y);
    logic [CALC_W-1:0] r;
    r = mod_sub(CALC_W'(x), CALC_W'(y), CALC_W'(Q));
    return r[COEF_W-1:0];
  endfunction

  assign busy    = (state != IDLE);
  assign host_wr = wr_en && (state == IDLE);
  assign normal  = found_d && found_n && (deg_n >= deg_d);

  // Scanning runs from the top index down, so the first nonzero seen is the leading term.
  always_comb begin
    n_scan     = n_mem[idx];
    d_scan     = d_mem[idx];
    found_n_nx = found_n | (n_scan != '0);
    found_d_nx = found_d | (d_scan != '0);
    deg_n_nx   = found_n ? deg_n : idx;
    deg_d_nx   = found_d ? deg_d : idx;
    lc_d_nx    = found_d ? lc_d : d_scan;
    upd_addr   = j + k;
    t_nx       = mulq(n_mem[deg_d + k], inv);
    n_upd      = subq(n_mem[upd_addr], mulq(t, d_mem[j]));
  end

  always_comb begin
    state_nx  = state;
    inv_start = 1'b0;
    case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: if (idx == '0) begin
        if (!found_d_nx || !found_n_nx || (deg_n_nx < deg_d_nx)) begin
          state_nx = FIN;
        end else begin
          state_nx  = INV;
          inv_start = 1'b1;
        end
      end
      INV:  if (inv_done) state_nx = QUOT;
      QUOT: state_nx = UPD;
      UPD:  if (j == deg_d) state_nx = (k == '0) ? FIN : QUOT;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      deg_q   <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == FIN);
      if (state == IDLE && start) err <= 1'b0;
      if (state == FIN) begin
        err   <= !found_d;
        deg_q <= normal ? deg_n - deg_d : '0;
      end
      if (rd_sel) rd_data <= (rd_addr < deg_d) ? n_mem[rd_addr] : '0;
      else        rd_data <= q_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        idx     <= LAST;
        found_n <= 1'b0;
        found_d <= 1'b0;
      end
      SCAN: begin
        found_n <= found_n_nx;
        found_d <= found_d_nx;
        deg_n   <= deg_n_nx;
        deg_d   <= deg_d_nx;
        lc_d    <= lc_d_nx;
        k       <= deg_n_nx - deg_d_nx;
        idx     <= idx - AW'(1);
      end
      QUOT: begin
        t <= t_nx;
        j <= '0;
      end
      UPD: if (j == deg_d) k <= k - AW'(1);
           else            j <= j + AW'(1);
      default: ;
    endcase
  end

  // NOTE: coefficient RAMs carry no reset so they map onto plain storage; contents come only from loads and updates.
  always_ff @(posedge clk) begin
    if (state == UPD)            n_mem[upd_addr] <= n_upd;
    else if (host_wr && !wr_sel) n_mem[wr_addr]  <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (host_wr && wr_sel) d_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (state == SCAN)      q_mem[idx] <= '0;
    else if (state == QUOT) q_mem[k]   <= t_nx;
  end

  modinv_fermat #(.COEF_W(COEF_W), .Q(Q)) u_inv (
    .clk  (clk),
    .rst  (rst),
    .start(inv_start),
    .a    (lc_d_nx),
    .done (inv_done),
    .inv  (inv)
  );
endmodule
